progmem_loader: RTL
===================

Name: progmem_loader

Overview:
Byte-stream boot loader that writes the 256 x 40-bit program memory the CPU core fetches from. It receives a framed image over a valid/ready byte interface (UART RX or debug bridge). It assembles 40-bit instruction words big-endian and writes them to consecutive program addresses from 0. It holds the CPU in reset until a frame with a correct checksum has been fully written.

Parameters:
ADDR_W, 8, program memory address width (depth 2**ADDR_W)
WORD_BYTES, 5, bytes per instruction word (word width 8*WORD_BYTES = 40)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes inside a frame before abort

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_rx_data  in  8  incoming byte
i_rx_valid  in  1  byte present
o_rx_ready  out  1  loader accepts byte this cycle; a byte transfers when valid && ready
o_pm_we  out  1  program memory write strobe, one cycle
o_pm_addr  out  ADDR_W  write address
o_pm_wdata  out  40  write data, first received byte in [39:32]
o_cpu_hold  out  1  hold CPU in reset / stall PC
o_done  out  1  image loaded and verified (level)
o_error  out  1  last frame failed (level, sticky until next SYNC accepted or reset)

Behaviour:
- Reset is synchronous to i_clk and active-high on i_rst. Reset values: state IDLE, o_rx_ready 0 during reset then 1, o_pm_we 0, o_pm_addr 0, o_pm_wdata 0, o_cpu_hold 1, o_done 0, o_error 0, checksum 0, timeout counter 0.
- States:
  - IDLE: accepts and discards every byte except SYNC_BYTE. On SYNC: go to COUNT, clear o_done and o_error, assert o_cpu_hold, zero the checksum.
  - COUNT: the accepted byte is N, the number of words; N=0 means 256. Latch the word count (ADDR_W+1 bits) and set the checksum to N. Go to DATA with byte index 0 and address 0.
  - DATA: shift each accepted byte into the 40-bit assembly register (MSB first) and XOR it into the checksum.
    - On the WORD_BYTES-th byte, the next cycle drives o_pm_we=1 with o_pm_addr = current address and o_pm_wdata = the assembled word.
    - The address increments after the write.
    - After the N-th word, go to CHECK.
  - CHECK: the accepted byte is compared with the running checksum. Equal -> DONE. Unequal -> ERROR.
  - DONE: o_done=1, o_cpu_hold=0. A SYNC byte restarts the load (back to COUNT, hold re-asserted). Any other byte is discarded.
  - ERROR: lasts one cycle. Sets o_error=1, keeps o_cpu_hold=1, returns to IDLE.
- Handshake:
  - o_rx_ready=1 in every state except the o_pm_we cycle and the ERROR cycle, where it is 0.
  - A byte presented while ready=0 is not consumed; the source holds it.
  - Write latency: last byte of a word accepted at cycle t -> o_pm_we at t+1 -> ready back at t+2.
- Timeout: in COUNT, DATA and CHECK, a counter increments each cycle with no accepted byte and clears on an accepted byte. Reaching TIMEOUT_CYCLES -> ERROR. Words already written are not rolled back.
- Address wrap: N=256 writes addresses 0..255. The address counter wraps to 0 only after the final write and is never used again in that frame.
- o_cpu_hold is 1 in all states except DONE. The CPU executes only a verified image.
- i_rst mid-frame: immediate return to reset values. Partially written memory is left as is; hold stays asserted.
- Within a frame, SYNC_BYTE is treated as data, not a marker.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, COUNT, DATA, CHECK, DONE, ERROR)
  - SYNC_BYTE
  - PM_WORD_W=40
  - PM_ADDR_W=8
- The CPU core and this block share PM_WORD_W and PM_ADDR_W.
- One natural sub-module: progmem_word_assembler (shift register, byte index counter, word-complete strobe). FSM, checksum and timeout stay in the top.

Test Plan:
- Single word: after reset, bytes A5 01 01 02 03 04 05 00 -> exactly one o_pm_we, addr 0, data 40'h0102030405. Then o_done=1, o_cpu_hold=0, o_error=0.
- Bad checksum: same frame with final byte 0x11 -> the word is still written. o_error=1, o_done=0, o_cpu_hold stays 1, state returns to IDLE.
- Full image: N=00, 1280 data bytes with word k = {5{k[7:0]}} (per-word XOR of five identical bytes = k), correct checksum -> 256 writes, addr 0..255 in order, o_done=1.
- Back-pressure: i_rx_valid held continuously -> o_rx_ready low exactly on each o_pm_we cycle. No byte lost or duplicated; all data matches.
- Timeout/noise: garbage bytes 00 FF 12 before SYNC are ignored. After A5 03 plus 2 bytes, stall TIMEOUT_CYCLES (set to 16 in the bench) -> o_error=1, no write issued.
- Reload and reset: after DONE, send A5 -> o_cpu_hold=1 and o_done=0 within 1 cycle. Assert i_rst mid-DATA -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/progmem_loader_pkg.sv
// Shared definitions for the program-memory boot loader and the CPU core that fetches from it.
package progmem_loader_pkg;

  localparam int PM_WORD_W = 40;
  localparam int PM_ADDR_W = 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  // Frame checksum is a plain XOR of the count byte and every data byte.
  function automatic logic [7:0] csum_add(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

endpackage

// File: rtl/progmem_loader_if.sv
// Byte-stream input, program-memory write port and CPU status lines of the boot loader.
interface progmem_loader_if import progmem_loader_pkg::*; #(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int WORD_W = PM_WORD_W
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [WORD_W-1:0] pm_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, pm_we, pm_addr, pm_wdata, cpu_hold, done, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, pm_we, pm_addr, pm_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/progmem_word_assembler.sv
// Packs accepted bytes MSB-first into an instruction word and strobes once per completed word.
module progmem_word_assembler import progmem_loader_pkg::*; #(
  parameter int WORD_BYTES = PM_WORD_W / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    byte_vld,
  input  logic [7:0]              byte_in,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_vld
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = $clog2(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0]  idx_p0;
  logic [WORD_W-1:0] shift_p0;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p0   <= '0;
      shift_p0 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= byte_vld && (idx_p0 == LAST_IDX);
      if (clear)
        idx_p0 <= '0;
      else if (byte_vld)
        idx_p0 <= (idx_p0 == LAST_IDX) ? '0 : idx_p0 + IDX_W'(1);
      if (byte_vld)
        shift_p0 <= {shift_p0[WORD_W-9:0], byte_in};
    end
  end

  // p1: the shift register is frozen while the strobe is high because the
  // loader drops ready for that cycle, so it doubles as the write data.
  assign word     = shift_p0;
  assign word_vld = vld_p1;

endmodule

// File: rtl/progmem_loader.sv
// Framed byte-stream boot loader: SYNC, word count, big-endian words, XOR checksum; holds the CPU until verified.
module progmem_loader import progmem_loader_pkg::*; #(
  parameter int         ADDR_W         = PM_ADDR_W,
  parameter int         WORD_BYTES     = PM_WORD_W / 8,
  parameter logic [7:0] SYNC_BYTE      = progmem_loader_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  progmem_loader_if.slave  bus
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q;
  logic [ADDR_W:0]   nwords_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        csum_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              error_q;

  logic              accept;
  logic              in_frame;
  logic              timeout;
  logic              last_word;
  logic              asm_vld;
  logic              asm_clear;
  logic              word_we;
  logic [WORD_W-1:0] word;

  assign bus.rx_ready = !i_rst && !word_we && (state_q != ST_ERROR);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign in_frame     = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign timeout      = in_frame && !accept && (tmo_q == TMO_LAST);
  assign last_word    = ({1'b0, addr_q} + (ADDR_W+1)'(1)) == nwords_q;
  assign asm_vld      = accept && (state_q == ST_DATA);
  assign asm_clear    = (state_q != ST_DATA);

  progmem_word_assembler #(
    .WORD_BYTES (WORD_BYTES)
  ) u_asm (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (asm_clear),
    .byte_vld (asm_vld),
    .byte_in  (bus.rx_data),
    .word     (word),
    .word_vld (word_we)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      nwords_q <= '0;
      addr_q   <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      if (word_we)
        addr_q <= addr_q + ADDR_W'(1);

      if (!in_frame || accept || timeout)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + TMO_W'(1);

      // Words already written stay in memory when a frame is abandoned.
      if (timeout) begin
        state_q <= ST_ERROR;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (accept && (bus.rx_data == SYNC_BYTE)) begin
              state_q <= ST_COUNT;
              error_q <= 1'b0;
              csum_q  <= '0;
            end
          end
          ST_COUNT: begin
            if (accept) begin
              nwords_q <= (bus.rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                : (ADDR_W+1)'(bus.rx_data);
              csum_q   <= bus.rx_data;
              addr_q   <= '0;
              state_q  <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (asm_vld)
              csum_q <= csum_add(csum_q, bus.rx_data);
            if (word_we && last_word)
              state_q <= ST_CHECK;
          end
          ST_CHECK: begin
            if (accept) begin
              if (bus.rx_data == csum_q) begin
                state_q <= ST_DONE;
              end else begin
                state_q <= ST_ERROR;
                error_q <= 1'b1;
              end
            end
          end
          ST_ERROR: state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.pm_we    = word_we;
  assign bus.pm_addr  = addr_q;
  assign bus.pm_wdata = word;
  assign bus.cpu_hold = (state_q != ST_DONE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.error    = error_q;

endmodule
